// File: rtl/vector_condition_unit.sv
// vector_condition_unit
// Execute-stage conditional-execution unit. Holds per-lane NZCV flags,
// evaluates the 4-bit condition code against them, produces the scalar
// execute-enable and per-lane predicate, gates the decode controls and
// updates the flags under condition. A sticky illegal-condition bit and a
// saturating squash counter are kept for debug/performance visibility.
// Flag nibble packing per lane is {V,C,Z,N} with N at bit 0.
module vector_condition_unit #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ValidE,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 VecE,
    input  logic [3:0]           CondE,
    input  logic [1:0]           FlagWriteE,
    input  logic [4*LANES-1:0]   ALUFlagsE,
    input  logic                 PCSrcE,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    output logic                 CondExE,
    output logic [LANES-1:0]     LaneMaskE,
    output logic                 PCSrcG,
    output logic                 RegWriteG,
    output logic                 MemWriteG,
    output logic [4*LANES-1:0]   FlagsQ,
    output logic                 IllegalCond,
    output logic [CNT_W-1:0]     SquashCount
);

    logic [4*LANES-1:0] r_flags;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_squash;

    logic               w_live;
    logic [LANES-1:0]   w_lane_pass;
    logic [LANES-1:0]   w_mask;
    logic               w_cex;
    logic [LANES-1:0]   w_lane_we;
    logic               w_commit;

    // Condition pass function on one lane's stored flags; 1111 never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[0];
        z = f[1];
        c = f[2];
        v = f[3];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = ~(n ^ v);
            4'b1011: cond_pass = n ^ v;
            4'b1100: cond_pass = ~z & ~(n ^ v);
            4'b1101: cond_pass = z | (n ^ v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Per-lane condition evaluation against pre-update (stored) flags.
    always_comb begin
        w_lane_pass = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_pass[i] = cond_pass(CondE, r_flags[4*i +: 4]);
        end
    end

    // Execute-enable, lane predicate and per-lane flag write enables.
    always_comb begin
        w_live    = ValidE & ~FlushE;
        w_commit  = w_live & ~StallE;
        w_mask    = '0;
        w_cex     = 1'b0;
        w_lane_we = '0;
        if (VecE) begin
            w_mask = {LANES{w_live}} & w_lane_pass;
            w_cex  = &w_mask;
        end else begin
            w_cex  = w_live & w_lane_pass[0];
            w_mask = {LANES{w_cex}};
        end
        for (int i = 0; i < LANES; i++) begin
            if (VecE) begin
                w_lane_we[i] = w_mask[i];
            end else if (i == 0) begin
                w_lane_we[i] = w_cex;
            end
        end
    end

    // Gated decode controls; the register file applies the lane mask itself.
    always_comb begin
        CondExE   = w_cex;
        LaneMaskE = w_mask;
        RegWriteG = RegWriteE & (VecE ? |w_mask : w_cex);
        MemWriteG = MemWriteE & w_cex;
        PCSrcG    = PCSrcE & w_cex;
    end

    // Conditional flag update: N,Z and C,V halves are written independently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= '0;
        end else if (!StallE) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_lane_we[i]) begin
                    if (FlagWriteE[1]) r_flags[4*i +: 2]     <= ALUFlagsE[4*i +: 2];
                    if (FlagWriteE[0]) r_flags[4*i + 2 +: 2] <= ALUFlagsE[4*i + 2 +: 2];
                end
            end
        end
    end

    // Sticky illegal-condition indicator, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal <= 1'b0;
        end else if (w_commit && (CondE == 4'b1111)) begin
            r_illegal <= 1'b1;
        end
    end

    // Saturating count of committed instructions whose condition failed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_squash <= '0;
        end else if (w_commit && !w_cex && (r_squash != {CNT_W{1'b1}})) begin
            r_squash <= r_squash + CNT_W'(1);
        end
    end

    assign FlagsQ      = r_flags;
    assign IllegalCond = r_illegal;
    assign SquashCount = r_squash;

endmodule

// File: doc/vector_condition_unit.md
# vector_condition_unit

Parametrised conditional-execution unit for the execute stage. It holds the architectural NZCV flags for each lane and evaluates the full 4-bit ARM-style condition set against them. It produces a scalar execute-enable and a per-lane predicate mask, gates branch, register-write and memory-write, and updates the flags under condition. It also keeps a sticky illegal-condition indicator and a saturating squash counter for debug and performance.

## Interface

Parameters:
- LANES, 4, number of vector lanes (≥1)
- CNT_W, 16, width of the squash counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ValidE  in  1  execute-stage instruction is valid
- StallE  in  1  hold: no state update this cycle
- FlushE  in  1  squash: instruction treated as bubble
- VecE  in  1  0 = scalar instruction, 1 = vector instruction
- CondE  in  4  condition code
- FlagWriteE  in  2  [1] = write N,Z; [0] = write C,V
- ALUFlagsE  in  4*LANES  new flags; lane i at [4i+3:4i], bit order {V,C,Z,N} (N at bit 0)
- PCSrcE, RegWriteE, MemWriteE  in  1 each  ungated decode controls
- CondExE  out  1  instruction executes
- LaneMaskE  out  LANES  per-lane execute predicate
- PCSrcG, RegWriteG, MemWriteG  out  1 each  gated controls
- FlagsQ  out  4*LANES  stored flags, same packing as ALUFlagsE
- IllegalCond  out  1  sticky illegal-condition flag
- SquashCount  out  CNT_W  saturating count of condition-failed instructions

## Operation

Per-lane pass function p(f), evaluated on stored flags f:
- 0000 EQ Z
- 0001 NE ~Z
- 0010 CS C
- 0011 CC ~C
- 0100 MI N
- 0101 PL ~N
- 0110 VS V
- 0111 VC ~V
- 1000 HI C&~Z
- 1001 LS ~C|Z
- 1010 GE ~(N^V)
- 1011 LT N^V
- 1100 GT ~Z&~(N^V)
- 1101 LE Z|(N^V)
- 1110 AL 1
- 1111 illegal: p = 0. Never X.

Qualification:
- live = ValidE & ~FlushE

Scalar mode (VecE=0):
- CondExE = live & p(lane 0)
- LaneMaskE = all ones when CondExE=1, otherwise all zeros

Vector mode (VecE=1):
- LaneMaskE[i] = live & p(lane i)
- CondExE = &LaneMaskE, i.e. all lanes must pass

Gated controls:
- RegWriteG = RegWriteE & (VecE ? |LaneMaskE : CondExE). The register file applies LaneMaskE per lane.
- MemWriteG = MemWriteE & CondExE
- PCSrcG = PCSrcE & CondExE

Flag update, at the rising edge, only when ~StallE:
- Scalar mode: lane 0 only, enabled by CondExE.
- Vector mode: lane i, enabled by LaneMaskE[i].
- FlagWriteE[1] loads N,Z from ALUFlagsE. FlagWriteE[0] loads C,V.
- Unwritten bits and unwritten lanes hold their values.

IllegalCond:
- Set when live & ~StallE & CondE==1111.
- Cleared only by reset.

SquashCount:
- Increments when live & ~StallE & ~CondExE.
- Saturates at 2^CNT_W-1, with no wrap.

## Timing

- All outputs except FlagsQ, IllegalCond and SquashCount are combinational from inputs and stored flags. Latency is 0 cycles.
- Flags written by instruction k are visible to instruction k+1 in the next cycle. There is no same-cycle forwarding; an instruction always sees pre-update flags.
- StallE=1: combinational outputs are still driven, but no register changes. A held instruction is counted exactly once, on the cycle StallE drops.
- FlushE=1: outputs behave as for a bubble (all gated outputs 0), with no flag, IllegalCond or counter update. FlushE has priority over StallE.
- ValidE=0: same as flush.
- Asynchronous reset (rst=0), effective immediately, including mid-stall:
  - FlagsQ = 0 (Z=0, so EQ fails)
  - IllegalCond = 0
  - SquashCount = 0
  - Combinational outputs follow from the reset state.
- The counter at saturation with another failed instruction stays at max.

## Test plan

- **Reset:** drop rst asynchronously mid-cycle with FlagsQ nonzero → FlagsQ=0, SquashCount=0, IllegalCond=0 before the next edge; EQ on lane 0 → CondExE=0.
- **Scalar compare then branch:** cycle 0 writes lane-0 flags Z=1 with FlagWriteE=11 and CondE=AL. Cycle 1 is a BEQ (CondE=0000, PCSrcE=1) → PCSrcG=1. Cycle 1 with BNE instead → PCSrcG=0 and SquashCount increments by 1.
- **Vector predicate (LANES=4):** stored N/V chosen so lanes 0 and 2 satisfy LT. Vector LT with RegWriteE=1 → LaneMaskE=0101, RegWriteG=1, CondExE=0, MemWriteG=0. Flags update in lanes 0 and 2 only.
- **Partial flag write:** FlagWriteE=10 with ALUFlagsE lane 0 = 1111 and stored 0000 → lane 0 becomes 0011 (N,Z set; C,V unchanged).
- **Stall/flush:** a failing instruction held 3 cycles under StallE, then released → SquashCount +1 only. The same instruction with FlushE=1 → no increment and no flag change.
- **Illegal/saturation:** CondE=1111 → CondExE=0 and IllegalCond=1, which stays set afterwards. With CNT_W=2 and 5 failed instructions → SquashCount=3.
